// File: rtl/rc_meas_sequencer_pkg.sv
// Shared types and defaults for the RC charge-time measurement sequencer.
// Holds the FSM encoding and the default counter/accumulator sizing.
package rc_meas_sequencer_pkg;

    localparam int CNT_W_DEF        = 24;
    localparam int ACC_W_DEF        = CNT_W_DEF + 3;
    localparam int DISCH_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        DISCHARGE,
        DONE
    } state_t;

    // Three extra bits absorb the sum of up to 8 full-scale samples.
    function automatic int acc_width(input int cnt_w);
        return cnt_w + 3;
    endfunction

endpackage

// File: rtl/rc_meas_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous single- or multi-bit levels.
// Both stages clear to 0 on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rc_meas_sequencer.sv
// Times RC charge-up against a comparator, averages 2^avg_log2 samples,
// and hands the mean out over a valid/ready result port.
module rc_meas_sequencer
    import rc_meas_sequencer_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DISCH_CYCLES = DISCH_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       avg_log2,
    input  logic             step_input,
    output logic             step_set,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             timeout
);

    localparam int ACC_W = acc_width(CNT_W);
    localparam int DW    = $clog2(DISCH_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [DW-1:0]    DISCH_LAST = DW'(DISCH_CYCLES - 1);

    state_t state;
    state_t next_state;

    logic             sin;
    logic [CNT_W-1:0] charge_cnt;
    logic [DW-1:0]    disch_cnt;
    logic [3:0]       sample_cnt;
    logic [1:0]       avg_q;
    logic [ACC_W-1:0] acc;

    logic sat;
    logic disch_done;
    logic runs_done;
    logic run_start;
    logic take_sample;
    logic enter_charge;
    logic enter_done;

    sync_2ff #(
        .W(1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (step_input),
        .q    (sin)
    );

    assign sat        = (charge_cnt == CNT_MAX);
    assign disch_done = (disch_cnt >= DISCH_LAST);
    assign runs_done  = (sample_cnt >= (4'd1 << avg_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) next_state = CHARGE;
            end
            CHARGE: begin
                if (sin || sat) next_state = DISCHARGE;
            end
            DISCHARGE: begin
                if (disch_done && !sin)
                    next_state = runs_done ? DONE : CHARGE;
            end
            DONE: begin
                if (result_ready) next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        run_start    = (state == IDLE) && start;
        take_sample  = (state == CHARGE) && (sin || sat);
        enter_charge = (state != CHARGE) && (next_state == CHARGE);
        enter_done   = (state == DISCHARGE) && (next_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_set     <= 1'b0;
            charge_cnt   <= '0;
            disch_cnt    <= '0;
            sample_cnt   <= '0;
            avg_q        <= '0;
            acc          <= '0;
            timeout      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            step_set <= (next_state == CHARGE);

            if (run_start) begin
                acc        <= '0;
                sample_cnt <= '0;
                timeout    <= 1'b0;
                avg_q      <= avg_log2;
            end

            if (enter_charge)
                charge_cnt <= '0;
            else if (state == CHARGE && !sin && !sat)
                charge_cnt <= charge_cnt + CNT_W'(1);

            // On saturation charge_cnt already equals the full-scale value.
            if (take_sample) begin
                acc        <= acc + ACC_W'(charge_cnt);
                sample_cnt <= sample_cnt + 4'd1;
                if (sat && !sin) timeout <= 1'b1;
            end

            if (state != DISCHARGE)
                disch_cnt <= '0;
            else if (!disch_done)
                disch_cnt <= disch_cnt + DW'(1);

            if (enter_done) begin
                result       <= CNT_W'(acc >> avg_q);
                result_valid <= 1'b1;
            end else if (state == DONE && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rc_meas_sequencer.sv
// Directed bench for rc_meas_sequencer with CNT_W=8 and a short discharge.
// Expected results are hand-computed from the comparator delays.
module tb_rc_meas_sequencer;

    localparam int CNT_W = 8;
    localparam int DISCH = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       avg_log2;
    logic             step_input;
    logic             step_set;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             timeout;

    int n_chk  = 0;
    int n_pass = 0;

    rc_meas_sequencer #(
        .CNT_W       (CNT_W),
        .DISCH_CYCLES(DISCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .avg_log2    (avg_log2),
        .step_input  (step_input),
        .step_set    (step_set),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_set(input logic lvl, input string tag);
        int n = 0;
        while (step_set !== lvl && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, step_set, lvl);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (result_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, result_valid, 1);
    endtask

    task automatic pulse_start(input logic [1:0] a);
        avg_log2 = a;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Comparator trips `dly` cycles after step_set rises.
    task automatic run_sample(input int dly, input bit hold);
        wait_set(1'b1, "set_rise");
        repeat (dly) @(posedge clk);
        #1;
        step_input = 1'b1;
        wait_set(1'b0, "set_fall");
        if (!hold) step_input = 1'b0;
    endtask

    task automatic low_gap(input string tag);
        int n = 0;
        while (step_set !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, (n >= DISCH), 1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("acc_busy", busy, 0);
        chk("acc_valid", result_valid, 0);
    endtask

    initial begin
        int rose;
        rst_n        = 1'b0;
        start        = 1'b0;
        avg_log2     = 2'd0;
        step_input   = 1'b0;
        result_ready = 1'b0;
        #1;
        chk("rst_step_set", step_set, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_rst", busy, 0);

        // single sample
        pulse_start(2'd0);
        chk("t1_busy", busy, 1);
        run_sample(10, 0);
        wait_valid("t1_valid");
        chk("t1_result", result, 12);
        chk("t1_timeout", timeout, 0);
        repeat (5) tick();
        chk("t1_hold_valid", result_valid, 1);
        chk("t1_hold_result", result, 12);
        accept();

        // saturation, ready held high throughout
        result_ready = 1'b1;
        avg_log2     = 2'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_busy", busy, 1);
        wait_valid("t3_valid");
        chk("t3_result", result, 255);
        chk("t3_timeout", timeout, 1);
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_valid_drop", result_valid, 0);
        result_ready = 1'b0;

        // four-sample average
        pulse_start(2'd2);
        chk("t2_timeout_clr", timeout, 0);
        run_sample(10, 0);
        low_gap("t2_gap1");
        run_sample(12, 0);
        low_gap("t2_gap2");
        run_sample(14, 0);
        low_gap("t2_gap3");
        run_sample(16, 0);
        wait_valid("t2_valid");
        chk("t2_result", result, 15);
        chk("t2_timeout", timeout, 0);
        accept();

        // backpressure with an ignored start
        pulse_start(2'd0);
        run_sample(30, 0);
        wait_valid("t4_valid");
        chk("t4_result", result, 32);
        for (int i = 0; i < 50; i++) begin
            if (i == 25) start = 1'b1;
            if (i == 26) start = 1'b0;
            tick();
            chk("t4_stable_valid", result_valid, 1);
            chk("t4_stable_result", result, 32);
        end
        accept();
        repeat (5) tick();
        chk("t4_no_queue", busy, 0);

        // reset mid-CHARGE
        pulse_start(2'd0);
        wait_set(1'b1, "t5_rise");
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_set_async", step_set, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_result_async", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_busy", busy, 0);
        chk("t5_valid", result_valid, 0);
        pulse_start(2'd0);
        run_sample(10, 0);
        wait_valid("t5_valid2");
        chk("t5_result", result, 12);
        accept();

        // comparator stuck high after first sample
        pulse_start(2'd1);
        run_sample(10, 1);
        rose = 0;
        for (int i = 0; i < 3 * DISCH; i++) begin
            tick();
            if (step_set !== 1'b0) rose++;
        end
        chk("t6_no_rise", rose, 0);
        chk("t6_busy", busy, 1);
        step_input = 1'b0;
        run_sample(20, 0);
        wait_valid("t6_valid");
        chk("t6_result", result, 17);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
